video_oled_frame_ctl: RTL and testbench
=======================================

Name: video_oled_frame_ctl

Overview:
- Frame sequencer that sits in front of the 24-bit-RGB to 8-bit OLED dither converter.
- Admits exactly one whole input frame per OLED frame request and drops all other input.
- Regenerates tuser/tlast from a configured geometry.
- Drives the 3-bit temporal-dither phase consumed by the converter, advancing it once per completed frame.
- Reports framing errors through sticky flags.

Parameters:
- TUSER_WIDTH, 1, AXI4-Stream tuser width; bit 0 = start of frame (SOF).
- TDATA_WIDTH, 24, pixel width, passed through unmodified.
- X_WIDTH, 10, width of the pixel-column counter and of param_width.
- Y_WIDTH, 10, width of the line counter and of param_height.

Ports:
- aresetn  in  1  synchronous active-low reset
- aclk  in  1  clock
- aclken  in  1  clock enable; low freezes all state
- enable  in  1  admit new frames; sampled only in IDLE
- param_width  in  X_WIDTH  pixels per line; must be >= 1
- param_height  in  Y_WIDTH  lines per frame; must be >= 1
- trigger  in  1  1-cycle OLED frame-request pulse
- clear  in  1  clears the sticky error flags
- s_axi4s_tuser  in  TUSER_WIDTH
- s_axi4s_tlast  in  1
- s_axi4s_tdata  in  TDATA_WIDTH
- s_axi4s_tvalid  in  1
- s_axi4s_tready  out  1
- m_axi4s_tuser  out  TUSER_WIDTH
- m_axi4s_tlast  out  1
- m_axi4s_tdata  out  TDATA_WIDTH
- m_axi4s_tvalid  out  1
- m_axi4s_tready  in  1
- phase  out  3  dither phase for the converter
- busy  out  1  high when state != IDLE
- frame_done  out  1  1-cycle pulse when a frame completes
- err_sof  out  1  sticky: SOF arrived mid-frame
- err_line  out  1  sticky: input tlast disagrees with the counters
- err_trig  out  1  sticky: trigger arrived while a request was already pending

Behaviour:
- Reset and clock enable:
  - Reset is synchronous on aresetn; clock is aclk.
  - Reset values: state IDLE, m_tvalid 0, phase 0, trig_pend 0, all error flags 0, frame_done 0.
  - Reset mid-frame discards everything in flight; no tlast is emitted.
  - When aclken = 0, no register updates and s_tready = 0.
- Trigger latch (trig_pend):
  - trigger sets trig_pend.
  - trig_pend clears when the state leaves WAIT_SOF into PASS.
  - trigger while trig_pend = 1 sets err_trig; the two requests merge into one.
- Handshake:
  - The output is a single register stage; latency is 1 cycle from input acceptance to m_tvalid.
  - In PASS and WAIT_SOF, s_tready = aclken & (~m_tvalid | m_tready).
  - In IDLE, s_tready = aclken (beats are dropped freely).
  - Payload holds while m_tvalid & ~m_tready.
- States:
  - IDLE: consume and drop every beat. If enable & trig_pend, go to WAIT_SOF.
  - WAIT_SOF: drop beats with tuser[0] = 0. An accepted beat with tuser[0] = 1 is forwarded with m_tuser[0] = 1; set x = 1 (or x = 0, y = 1 when param_width = 1), then go to PASS.
  - PASS: forward every accepted beat and advance x. When x == param_width-1, x wraps to 0 and y increments.
- Output sideband regeneration:
  - m_tlast = (x == param_width-1).
  - m_tuser[0] = 1 only at (0,0); upper tuser bits pass through.
- Line-length check: input tlast != (x == param_width-1) on an accepted beat sets err_line. The beat is still forwarded, carrying the regenerated tlast.
- Frame completion:
  - When the beat at (param_width-1, param_height-1) is accepted: go to IDLE, increment phase mod 8, pulse frame_done on that cycle.
  - frame_done pulses on input acceptance, before the final output beat drains.
- Mid-frame SOF (tuser[0] = 1 in PASS at any position other than (0,0)):
  - Do not accept the beat (s_tready = 0 that cycle).
  - Set err_sof, go to WAIT_SOF, phase unchanged.
  - The stalled SOF beat then starts a new frame without needing a new trigger.
- Error flag clearing: clear zeroes all sticky flags; a set in the same cycle wins.
- Parameter changes: param_width and param_height are sampled continuously and must be held stable while busy; changes while busy are undefined.

Optional Feature:
- Macro: VIDEO_OLED_FRAME_CTL_FRMCNT_EN.
- Defined: adds outputs frm_pass[15:0] and frm_drop[15:0], both reset to 0 and cleared by clear.
  - frm_pass counts frame_done pulses.
  - frm_drop counts SOF beats dropped in IDLE.
  - Both counters wrap at 0xFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package video_oled_pkg holds:
  - state encoding localparams: IDLE = 2'd0, WAIT_SOF = 2'd1, PASS = 2'd2;
  - PHASE_WIDTH = 3, shared with the dither converter.
- One natural sub-module: video_oled_out_reg, the single-stage AXI4-Stream output register with hold-on-stall.

Test Plan:
- width = 4, height = 2, enable = 1, one trigger, then a clean 8-beat frame with data 0..7 -> 8 output beats; tuser on beat 0; tlast on beats 3 and 7; phase 0→1; one frame_done.
- No trigger, two clean frames -> all 16 beats accepted with s_tready = 1; m_tvalid never rises; phase stays 0; frm_drop = 2 when the macro is defined.
- Trigger, then SOF arrives at beat 5 of frame A -> err_sof = 1; the output restarts with tuser on that beat; phase is still 0 until the new frame completes, then becomes 1.
- Input tlast at beat 2 instead of 3 (width = 4) -> err_line = 1; output tlast is still on beat 3; clear on the following cycle -> err_line = 0.
- m_tready toggled 1/0 every cycle during the frame -> output sequence identical to scenario 1 with no loss or duplication; s_tready low while output is full and stalled.
- Two triggers 3 cycles apart, then aresetn = 0 mid-frame -> err_trig = 1 before the reset; after reset all outputs take their reset values, phase = 0, and the next frame requires a new trigger.

Source files
------------

// File: rtl/video_oled_pkg.sv
// Shared definitions for the OLED frame sequencer and the dither converter.
//   IDLE / WAIT_SOF / PASS : frame sequencer state encoding
//   PHASE_WIDTH            : width of the temporal-dither phase
package video_oled_pkg;

    localparam int PHASE_WIDTH = 3;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SOF = 2'd1;
    localparam logic [1:0] PASS     = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = IDLE,
        S_WAIT_SOF = WAIT_SOF,
        S_PASS     = PASS
    } state_t;

endpackage

// File: rtl/video_oled_frame_ctl_if.sv
// AXI4-Stream bundle used on both sides of the frame sequencer.
//   tuser  : sideband, bit 0 = start of frame
//   tlast  : end of line
//   tdata  : pixel
//   tvalid / tready : handshake
// master drives payload and tvalid; slave drives tready.
interface video_oled_frame_ctl_if #(
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 24
);
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tuser, tlast, tdata, tvalid, input tready);
    modport slave  (input tuser, tlast, tdata, tvalid, output tready);
endinterface

// File: rtl/video_oled_out_reg.sv
// Single-stage AXI4-Stream output register with hold-on-stall.
//   aclk, aresetn (sync, active-low), aclken (freezes all state when low)
//   load              : capture in_* this cycle (caller guarantees space)
//   in_tuser/tlast/tdata : payload to capture
//   space             : register is empty or draining this cycle
//   m_axi4s           : registered stream output (master side)
module video_oled_out_reg #(
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 24
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   aclken,
    input  logic                   load,
    input  logic [TUSER_WIDTH-1:0] in_tuser,
    input  logic                   in_tlast,
    input  logic [TDATA_WIDTH-1:0] in_tdata,
    output logic                   space,
    video_oled_frame_ctl_if.master m_axi4s
);

    logic                   valid_q;
    logic [TUSER_WIDTH-1:0] tuser_q;
    logic                   tlast_q;
    logic [TDATA_WIDTH-1:0] tdata_q;

    assign space = ~valid_q | m_axi4s.tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
        end else if (aclken) begin
            if (load) begin
                valid_q <= 1'b1;
            end else if (m_axi4s.tready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Payload only moves on load, and load is only issued when there is
    // space, so a stalled beat holds by construction.
    always_ff @(posedge aclk) begin
        if (aclken && load) begin
            tuser_q <= in_tuser;
            tlast_q <= in_tlast;
            tdata_q <= in_tdata;
        end
    end

    assign m_axi4s.tvalid = valid_q;
    assign m_axi4s.tuser  = tuser_q;
    assign m_axi4s.tlast  = tlast_q;
    assign m_axi4s.tdata  = tdata_q;

endmodule

// File: rtl/video_oled_frame_ctl.sv
// Frame sequencer in front of the 24-bit RGB -> 8-bit OLED dither converter.
// Admits one whole input frame per OLED frame request, regenerates
// tuser/tlast from param_width x param_height, advances the dither phase
// once per completed frame and reports framing errors via sticky flags.
//
// Ports:
//   aclk, aresetn (sync, active-low), aclken (low freezes all state)
//   enable        : admit new frames (looked at only in IDLE)
//   param_width   : pixels per line (>= 1), param_height: lines per frame (>= 1)
//   trigger       : 1-cycle OLED frame request
//   clear         : clears sticky error flags (and frame counters)
//   s_axi4s       : input stream (slave),  m_axi4s: output stream (master)
//   phase         : dither phase, busy: not IDLE, frame_done: 1-cycle pulse
//   err_sof / err_line / err_trig : sticky framing errors
//
// Build option VIDEO_OLED_FRAME_CTL_FRMCNT_EN adds frm_pass / frm_drop
// (frames completed / SOF beats dropped in IDLE, 16-bit wrapping).
//
// state    | meaning
// IDLE     | drop all input; leave when enabled and a request is pending
// WAIT_SOF | drop input until a SOF beat, which starts the frame at (0,0)
// PASS     | forward beats and track (x,y) until the last pixel
module video_oled_frame_ctl
    import video_oled_pkg::*;
#(
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 24,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 10
) (
    input  logic                   aresetn,
    input  logic                   aclk,
    input  logic                   aclken,
    input  logic                   enable,
    input  logic [X_WIDTH-1:0]     param_width,
    input  logic [Y_WIDTH-1:0]     param_height,
    input  logic                   trigger,
    input  logic                   clear,
    video_oled_frame_ctl_if.slave  s_axi4s,
    video_oled_frame_ctl_if.master m_axi4s,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_sof,
    output logic                   err_line,
    output logic                   err_trig
`ifdef VIDEO_OLED_FRAME_CTL_FRMCNT_EN
    ,
    output logic [15:0]            frm_pass,
    output logic [15:0]            frm_drop
`endif
);

    state_t                 state_q, state_d;
    logic [X_WIDTH-1:0]     x_q, x_d, pos_x, x_last;
    logic [Y_WIDTH-1:0]     y_q, y_d, pos_y, y_last;
    logic                   trig_pend_q;
    logic                   out_space;
    logic                   s_tready_c;
    logic                   fwd;
    logic                   leave_wait;
    logic                   mid_sof;
    logic                   line_end;
    logic                   frame_end;
    logic                   done_evt;
    logic [TUSER_WIDTH-1:0] tuser_fwd;

    assign x_last = param_width - 1'b1;
    assign y_last = param_height - 1'b1;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        pos_x      = x_q;
        pos_y      = y_q;
        s_tready_c = 1'b0;
        fwd        = 1'b0;
        leave_wait = 1'b0;
        mid_sof    = 1'b0;

        if (aclken) begin
            case (state_q)
                S_IDLE: begin
                    s_tready_c = 1'b1;
                    if (enable && trig_pend_q) begin
                        state_d = S_WAIT_SOF;
                    end
                end
                S_WAIT_SOF: begin
                    // The SOF beat is pixel (0,0) regardless of stale counters.
                    pos_x      = '0;
                    pos_y      = '0;
                    s_tready_c = out_space;
                    if (s_axi4s.tvalid && out_space && s_axi4s.tuser[0]) begin
                        fwd        = 1'b1;
                        leave_wait = 1'b1;
                        state_d    = S_PASS;
                    end
                end
                S_PASS: begin
                    // (0,0) is never reached inside PASS, so any SOF here is
                    // mid-frame: stall it and let WAIT_SOF take it next cycle.
                    if (s_axi4s.tvalid && s_axi4s.tuser[0]) begin
                        mid_sof = 1'b1;
                        state_d = S_WAIT_SOF;
                    end else begin
                        s_tready_c = out_space;
                        fwd        = s_axi4s.tvalid && out_space;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        line_end  = (pos_x == x_last);
        frame_end = line_end && (pos_y == y_last);

        if (fwd) begin
            if (line_end) begin
                x_d = '0;
                y_d = pos_y + 1'b1;
            end else begin
                x_d = pos_x + 1'b1;
                y_d = pos_y;
            end
            // Covers a 1x1 frame finishing straight out of WAIT_SOF too.
            if (frame_end) begin
                state_d = S_IDLE;
            end
        end
    end

    assign done_evt = fwd && frame_end;

    always_comb begin
        tuser_fwd    = s_axi4s.tuser;
        tuser_fwd[0] = (pos_x == '0) && (pos_y == '0);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            trig_pend_q <= 1'b0;
            phase       <= '0;
            frame_done  <= 1'b0;
            err_sof     <= 1'b0;
            err_line    <= 1'b0;
            err_trig    <= 1'b0;
        end else if (aclken) begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            trig_pend_q <= trigger | (trig_pend_q & ~leave_wait);
            frame_done  <= done_evt;
            if (done_evt) begin
                phase <= phase + 1'b1;
            end
            err_sof  <= mid_sof | (err_sof & ~clear);
            err_line <= (fwd && (s_axi4s.tlast != line_end)) | (err_line & ~clear);
            err_trig <= (trigger & trig_pend_q) | (err_trig & ~clear);
        end
    end

    assign s_axi4s.tready = s_tready_c;
    assign busy           = (state_q != S_IDLE);

    video_oled_out_reg #(
        .TUSER_WIDTH (TUSER_WIDTH),
        .TDATA_WIDTH (TDATA_WIDTH)
    ) u_out_reg (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .aclken   (aclken),
        .load     (fwd),
        .in_tuser (tuser_fwd),
        .in_tlast (line_end),
        .in_tdata (s_axi4s.tdata),
        .space    (out_space),
        .m_axi4s  (m_axi4s)
    );

`ifdef VIDEO_OLED_FRAME_CTL_FRMCNT_EN
    logic drop_sof;

    assign drop_sof = aclken && (state_q == S_IDLE) && s_axi4s.tvalid && s_axi4s.tuser[0];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            frm_pass <= '0;
            frm_drop <= '0;
        end else if (aclken) begin
            frm_pass <= (clear ? 16'd0 : frm_pass) + {15'd0, done_evt};
            frm_drop <= (clear ? 16'd0 : frm_drop) + {15'd0, drop_sof};
        end
    end
`endif

endmodule

// File: tb/tb_video_oled_frame_ctl.sv
module tb_video_oled_frame_ctl;
    import video_oled_pkg::*;

    localparam int TW = 1;
    localparam int DW = 24;
    localparam int XW = 10;
    localparam int YW = 10;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic          aclken  = 1'b1;
    logic          enable  = 1'b1;
    logic          trigger = 1'b0;
    logic          clear   = 1'b0;
    logic [XW-1:0] param_width  = 10'd4;
    logic [YW-1:0] param_height = 10'd2;
    logic [2:0]    phase;
    logic          busy, frame_done, err_sof, err_line, err_trig;
`ifdef VIDEO_OLED_FRAME_CTL_FRMCNT_EN
    logic [15:0]   frm_pass, frm_drop;
`endif

    video_oled_frame_ctl_if #(.TUSER_WIDTH(TW), .TDATA_WIDTH(DW)) s_if ();
    video_oled_frame_ctl_if #(.TUSER_WIDTH(TW), .TDATA_WIDTH(DW)) m_if ();

    video_oled_frame_ctl #(
        .TUSER_WIDTH (TW),
        .TDATA_WIDTH (DW),
        .X_WIDTH     (XW),
        .Y_WIDTH     (YW)
    ) dut (
        .aresetn      (aresetn),
        .aclk         (aclk),
        .aclken       (aclken),
        .enable       (enable),
        .param_width  (param_width),
        .param_height (param_height),
        .trigger      (trigger),
        .clear        (clear),
        .s_axi4s      (s_if),
        .m_axi4s      (m_if),
        .phase        (phase),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_sof      (err_sof),
        .err_line     (err_line),
        .err_trig     (err_trig)
`ifdef VIDEO_OLED_FRAME_CTL_FRMCNT_EN
        ,
        .frm_pass     (frm_pass),
        .frm_drop     (frm_drop)
`endif
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Output monitor and ready driver
    logic [25:0] got_q[$];
    logic [25:0] exp_q[$];
    logic [23:0] frm_data[$];
    int   done_cnt    = 0;
    int   rise_cnt    = 0;
    int   stall_viol  = 0;
    int   total_waits = 0;
    int   rdy_mode    = 0;
    logic prev_valid  = 1'b0;
    int   exp_phase   = 0;

    always @(negedge aclk) begin
        if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tuser[0], m_if.tlast, m_if.tdata});
        if (frame_done) done_cnt++;
        if (m_if.tvalid && !prev_valid) rise_cnt++;
        prev_valid = m_if.tvalid;
        if (busy && m_if.tvalid && !m_if.tready && s_if.tready) stall_viol++;
    end

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = ~m_if.tready;
            default: m_if.tready = ($urandom_range(0, 1) == 1);
        endcase
    end

    task automatic drive_phase();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_phase();
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        drive_phase();
        trigger = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        drive_phase();
        clear = 1'b0;
    endtask

    task automatic send_beat(input logic u, input logic l, input logic [23:0] d);
        bit ok;
        s_if.tvalid = 1'b1;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tdata  = d;
        for (int n = 0; n < 500; n++) begin
            @(negedge aclk);
            ok = s_if.tready;
            total_waits++;
            drive_phase();
            if (ok) return;
        end
        check_val("accept_timeout", 32'd0, 32'd1);
    endtask

    // Sends nb beats of a w-wide frame; tlast is flipped on beats fa and fb.
    task automatic send_frame(input int w, input int nb, input int fa, input int fb,
                              input bit seq, input bit gaps);
        frm_data.delete();
        for (int i = 0; i < nb; i++) begin
            logic        lst;
            logic [23:0] d;
            lst = ((i % w) == w - 1);
            if (i == fa || i == fb) lst = ~lst;
            d = seq ? 24'(i) : 24'($urandom);
            frm_data.push_back(d);
            send_beat(i == 0, lst, d);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_if.tvalid = 1'b0;
                drive_phase();
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    // Reference: beat i of a frame sits at column i%w; SOF at i==0, tlast at the last column.
    task automatic expect_frame(input int w, input int nb);
        for (int i = 0; i < nb; i++)
            exp_q.push_back({(i == 0), ((i % w) == w - 1), frm_data[i]});
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge aclk);
        while (m_if.tvalid && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) check_val("drain_timeout", 32'd0, 32'd1);
        drive_phase();
        idle(2);
    endtask

    task automatic compare_stream(input string tag);
        check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_val($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        idle(3);
        aresetn = 1'b1;

        // Reset state
        @(negedge aclk);
        check_val("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check_val("rst_phase", 32'(phase), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_errs", 32'({err_sof, err_line, err_trig}), 32'd0);
        check_val("rst_idle_tready", 32'(s_if.tready), 32'd1);
        drive_phase();

        // Clean 4x2 frame with data 0..7
        done_cnt = 0;
        pulse_trigger();
        idle(2);
        send_frame(4, 8, -1, -1, 1'b1, 1'b0);
        expect_frame(4, 8);
        exp_phase = (exp_phase + 1) % 8;
        drain();
        compare_stream("clean");
        check_val("clean_phase", 32'(phase), 32'(exp_phase));
        check_val("clean_done_cnt", 32'(done_cnt), 32'd1);
        check_val("clean_errs", 32'({err_sof, err_line, err_trig}), 32'd0);
        check_val("clean_busy", 32'(busy), 32'd0);

        // No trigger: two frames dropped freely
        rise_cnt    = 0;
        total_waits = 0;
        send_frame(4, 8, -1, -1, 1'b0, 1'b0);
        send_frame(4, 8, -1, -1, 1'b0, 1'b0);
        idle(3);
        check_val("drop_waits", 32'(total_waits), 32'd16);
        check_val("drop_rise", 32'(rise_cnt), 32'd0);
        check_val("drop_out_count", 32'(got_q.size()), 32'd0);
        check_val("drop_phase", 32'(phase), 32'(exp_phase));
`ifdef VIDEO_OLED_FRAME_CTL_FRMCNT_EN
        check_val("frm_drop", 32'(frm_drop), 32'd2);
        check_val("frm_pass", 32'(frm_pass), 32'd1);
`endif

        // Mid-frame SOF at beat 5 of frame A
        done_cnt = 0;
        pulse_trigger();
        idle(2);
        send_frame(4, 5, -1, -1, 1'b0, 1'b0);
        expect_frame(4, 5);
        @(negedge aclk);
        check_val("midsof_phase_hold", 32'(phase), 32'(exp_phase));
        drive_phase();
        send_frame(4, 8, -1, -1, 1'b0, 1'b0);
        expect_frame(4, 8);
        exp_phase = (exp_phase + 1) % 8;
        drain();
        compare_stream("midsof");
        check_val("midsof_err_sof", 32'(err_sof), 32'd1);
        check_val("midsof_phase", 32'(phase), 32'(exp_phase));
        check_val("midsof_done_cnt", 32'(done_cnt), 32'd1);
        pulse_clear();
        @(negedge aclk);
        check_val("clear_err_sof", 32'(err_sof), 32'd0);
        drive_phase();

        // Early input tlast on beat 2 instead of 3
        pulse_trigger();
        idle(2);
        send_frame(4, 8, 2, 3, 1'b0, 1'b0);
        expect_frame(4, 8);
        exp_phase = (exp_phase + 1) % 8;
        drain();
        compare_stream("badlast");
        check_val("badlast_err_line", 32'(err_line), 32'd1);
        pulse_clear();
        @(negedge aclk);
        check_val("clear_err_line", 32'(err_line), 32'd0);
        check_val("badlast_phase", 32'(phase), 32'(exp_phase));
        drive_phase();

        // Toggling backpressure
        rdy_mode   = 1;
        stall_viol = 0;
        pulse_trigger();
        idle(2);
        send_frame(4, 8, -1, -1, 1'b1, 1'b0);
        expect_frame(4, 8);
        exp_phase = (exp_phase + 1) % 8;
        drain();
        compare_stream("toggle");
        check_val("toggle_stall_tready", 32'(stall_viol), 32'd0);
        check_val("toggle_phase", 32'(phase), 32'(exp_phase));

        // Random geometries, data, gaps and backpressure
        rdy_mode = 2;
        for (int k = 0; k < 6; k++) begin
            int w, h;
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            param_width  = XW'(w);
            param_height = YW'(h);
            idle(1);
            pulse_trigger();
            idle(2);
            send_frame(w, w * h, -1, -1, 1'b0, 1'b1);
            expect_frame(w, w * h);
            exp_phase = (exp_phase + 1) % 8;
            drain();
            compare_stream($sformatf("rand%0d_%0dx%0d", k, w, h));
            check_val($sformatf("rand%0d_phase", k), 32'(phase), 32'(exp_phase));
        end
        check_val("rand_err_line", 32'(err_line), 32'd0);
        check_val("rand_stall_tready", 32'(stall_viol), 32'd0);

        // Double trigger, then reset mid-frame
        rdy_mode     = 0;
        param_width  = 10'd4;
        param_height = 10'd2;
        idle(1);
        pulse_trigger();
        idle(2);
        pulse_trigger();
        @(negedge aclk);
        check_val("dbl_err_trig", 32'(err_trig), 32'd1);
        drive_phase();
        send_frame(4, 3, -1, -1, 1'b0, 1'b0);
        aresetn = 1'b0;
        idle(2);
        aresetn = 1'b1;
        @(negedge aclk);
        check_val("rst2_tvalid", 32'(m_if.tvalid), 32'd0);
        check_val("rst2_phase", 32'(phase), 32'd0);
        check_val("rst2_busy", 32'(busy), 32'd0);
        check_val("rst2_frame_done", 32'(frame_done), 32'd0);
        check_val("rst2_errs", 32'({err_sof, err_line, err_trig}), 32'd0);
`ifdef VIDEO_OLED_FRAME_CTL_FRMCNT_EN
        check_val("rst2_frm_pass", 32'(frm_pass), 32'd0);
`endif
        drive_phase();
        got_q.delete();
        exp_q.delete();
        rise_cnt = 0;
        send_frame(4, 8, -1, -1, 1'b0, 1'b0);
        idle(3);
        check_val("rst2_no_trig_rise", 32'(rise_cnt), 32'd0);
        check_val("rst2_no_trig_out", 32'(got_q.size()), 32'd0);
        check_val("rst2_no_trig_phase", 32'(phase), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
